// File: rtl/keypad_scan_ctrl.sv
// 4x4 matrix keypad scanner: one-cold column drive, settle-then-sample rows,
// multi-scan debounce and a valid/ack key event. Define KEYPAD_OVERRUN_EN for the sticky overrun flag.
module keypad_scan_ctrl #(
  parameter int SETTLE_CYCLES  = 1000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [3:0] row,
  output logic [3:0] column,
  output logic [3:0] key_code,
  output logic       key_valid,
  input  logic       key_ack,
  output logic       key_pressed
`ifdef KEYPAD_OVERRUN_EN
  ,
  output logic       overrun
`endif
);

  localparam int         CNT_W   = (SETTLE_CYCLES > 2) ? $clog2(SETTLE_CYCLES) : 2;
  localparam logic [3:0] DEB_MAX = 4'(DEBOUNCE_SCANS);

  typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, EOS} state_e;

  state_e             state_q, state_d;
  logic [1:0]         col_idx_q, col_idx_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [15:0]        snapshot_q, snapshot_d;
  logic [15:0]        prev_q, prev_d;
  logic [15:0]        deb_q, deb_d;
  logic [3:0]         stable_q, stable_d;
  logic [3:0]         row_meta_q, row_sync_q;
  logic [3:0]         key_code_q, key_code_d;
  logic               key_valid_q, key_valid_d;
  logic               key_pressed_q;
  logic               scan_done;
  logic               new_event;
  logic               ack_take;

  function automatic logic [3:0] bit_index(input logic [15:0] m);
    bit_index = '0;
    for (int i = 0; i < 16; i++) begin
      if (m[i]) bit_index = 4'(i);
    end
  endfunction

  // Rows idle high through the pull-ups, so the synchronizer resets to "no key".
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_meta_q <= 4'hF;
      row_sync_q <= 4'hF;
    end else begin
      row_meta_q <= row;
      row_sync_q <= row_meta_q;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no latch is inferred.
    state_d    = state_q;
    col_idx_d  = col_idx_q;
    cnt_d      = cnt_q;
    snapshot_d = snapshot_q;
    column     = 4'hF;
    scan_done  = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable) begin
          state_d   = DRIVE;
          col_idx_d = 2'd0;
          cnt_d     = '0;
        end
      end
      DRIVE: begin
        column = ~(4'b0001 << col_idx_q);
        if (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = SAMPLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      SAMPLE: begin
        column = ~(4'b0001 << col_idx_q);
        snapshot_d[{col_idx_q, 2'b00} +: 4] = ~row_sync_q;
        if (col_idx_q == 2'd3) begin
          state_d = EOS;
        end else begin
          col_idx_d = col_idx_q + 2'd1;
          state_d   = DRIVE;
        end
      end
      EOS: begin
        scan_done = 1'b1;
        col_idx_d = 2'd0;
        cnt_d     = '0;
        state_d   = DRIVE;
      end
      default: state_d = IDLE;
    endcase
    if (!enable) begin
      state_d   = IDLE;
      col_idx_d = 2'd0;
      cnt_d     = '0;
    end
  end

  // The debounced map moves only on the scan where the stable count first reaches its target.
  always_comb begin
    prev_d   = prev_q;
    stable_d = stable_q;
    deb_d    = deb_q;
    if (scan_done) begin
      if (snapshot_q == prev_q) begin
        if (stable_q != DEB_MAX) begin
          stable_d = stable_q + 4'd1;
          if (stable_q + 4'd1 == DEB_MAX) deb_d = snapshot_q;
        end
      end else begin
        prev_d   = snapshot_q;
        stable_d = 4'd1;
        if (DEB_MAX == 4'd1) deb_d = snapshot_q;
      end
    end
  end

  assign new_event = scan_done && (deb_q == 16'h0) && $onehot(deb_d);
  assign ack_take  = key_valid_q && key_ack;

  always_comb begin
    key_code_d  = key_code_q;
    key_valid_d = key_valid_q;
    if (ack_take) key_valid_d = 1'b0;
    if (new_event && (!key_valid_q || key_ack)) begin
      key_code_d  = bit_index(deb_d);
      key_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      col_idx_q     <= 2'd0;
      cnt_q         <= '0;
      snapshot_q    <= 16'h0;
      prev_q        <= 16'h0;
      deb_q         <= 16'h0;
      stable_q      <= 4'd0;
      key_code_q    <= 4'h0;
      key_valid_q   <= 1'b0;
      key_pressed_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      col_idx_q     <= col_idx_d;
      cnt_q         <= cnt_d;
      snapshot_q    <= snapshot_d;
      prev_q        <= prev_d;
      deb_q         <= deb_d;
      stable_q      <= stable_d;
      key_code_q    <= key_code_d;
      key_valid_q   <= key_valid_d;
      key_pressed_q <= (deb_d != 16'h0);
    end
  end

`ifdef KEYPAD_OVERRUN_EN
  logic overrun_q, overrun_d;

  always_comb begin
    overrun_d = overrun_q;
    if (ack_take) overrun_d = 1'b0;
    if (new_event && key_valid_q && !key_ack) overrun_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) overrun_q <= 1'b0;
    else     overrun_q <= overrun_d;
  end

  assign overrun = overrun_q;
`endif

  assign key_code    = key_code_q;
  assign key_valid   = key_valid_q;
  assign key_pressed = key_pressed_q;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Directed bench for keypad_scan_ctrl with SETTLE_CYCLES=4, DEBOUNCE_SCANS=3 (21-cycle scan).
// A keypad model pulls a row low whenever a pressed key's column is driven low.
module tb_keypad_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic [3:0] row;
  logic [3:0] column;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_ack;
  logic       key_pressed;
`ifdef KEYPAD_OVERRUN_EN
  logic       overrun;
`endif

  logic [15:0] keys;
  logic [3:0]  exp_col;
  int          cyc;
  int          total = 0;
  int          bad   = 0;

  keypad_scan_ctrl #(.SETTLE_CYCLES(4), .DEBOUNCE_SCANS(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .row        (row),
    .column     (column),
    .key_code   (key_code),
    .key_valid  (key_valid),
    .key_ack    (key_ack),
    .key_pressed(key_pressed)
`ifdef KEYPAD_OVERRUN_EN
    ,
    .overrun    (overrun)
`endif
  );

  always #5 clk = ~clk;

  always_comb begin
    row = 4'hF;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        if (keys[c*4+r] && !column[c]) row[r] = 1'b0;
      end
    end
  end

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h (cyc=%0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int n);
    while (cyc < n) tick();
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; key_ack = 1'b0; keys = 16'h0; cyc = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Idle after reset
    for (int i = 0; i < 100; i++) begin
      tick();
      if (i % 25 == 24) begin
        check("idle_column", 16'(column), 16'hF);
        check("idle_valid", 16'(key_valid), 16'h0);
        check("idle_code", 16'(key_code), 16'h0);
        check("idle_pressed", 16'(key_pressed), 16'h0);
      end
    end
`ifdef KEYPAD_OVERRUN_EN
    check("idle_overrun", 16'(overrun), 16'h0);
`endif

    // Column sequencing over two full scans
    enable = 1'b1;
    tick();
    for (int s = 0; s < 2; s++) begin
      for (int c = 0; c < 4; c++) begin
        for (int k = 0; k < 5; k++) begin
          exp_col = ~(4'b0001 << c);
          check("seq_column", 16'(column), 16'(exp_col));
          tick();
        end
      end
      check("seq_eos", 16'(column), 16'hF);
      tick();
    end
    repeat (7) tick();
    check("mid_scan_col1", 16'(column), 16'hD);
    enable = 1'b0;
    tick();
    check("disable_column", 16'(column), 16'hF);
    tick();
    check("disable_hold", 16'(column), 16'hF);
    enable = 1'b1;
    tick();
    check("reenable_col0", 16'(column), 16'hE);

    // Asynchronous reset in the middle of DRIVE
    repeat (2) tick();
    rst = 1'b1;
    #1;
    check("rst_async_column", 16'(column), 16'hF);
    check("rst_async_valid", 16'(key_valid), 16'h0);
    enable = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;

    // Single press of key 6, held from the first scan
    keys = 16'h0040;
    tick();
    enable = 1'b1;
    cyc = 0;
    run_to(63);
    check("k6_before_valid", 16'(key_valid), 16'h0);
    check("k6_before_pressed", 16'(key_pressed), 16'h0);
    run_to(64);
    check("k6_valid", 16'(key_valid), 16'h1);
    check("k6_code", 16'(key_code), 16'h6);
    check("k6_pressed", 16'(key_pressed), 16'h1);
    key_ack = 1'b1;
    run_to(65);
    key_ack = 1'b0;
    check("k6_ack_clears", 16'(key_valid), 16'h0);
    check("k6_code_kept", 16'(key_code), 16'h6);
    run_to(127);
    check("k6_no_repeat", 16'(key_valid), 16'h0);
    check("k6_still_pressed", 16'(key_pressed), 16'h1);
    keys = 16'h0;
    run_to(189);
    check("k6_release_early", 16'(key_pressed), 16'h1);
    run_to(190);
    check("k6_released", 16'(key_pressed), 16'h0);

    // Bouncing key A: toggles for four scans, then held
    for (int b = 0; b < 4; b++) begin
      keys = (b % 2 == 0) ? 16'h0400 : 16'h0000;
      run_to(190 + 21 * (b + 1));
    end
    keys = 16'h0400;
    run_to(336);
    check("bounce_no_early_event", 16'(key_valid), 16'h0);
    check("bounce_not_pressed", 16'(key_pressed), 16'h0);
    run_to(337);
    check("bounce_valid", 16'(key_valid), 16'h1);
    check("bounce_code", 16'(key_code), 16'hA);
    key_ack = 1'b1;
    run_to(338);
    key_ack = 1'b0;
    check("bounce_ack", 16'(key_valid), 16'h0);
    keys = 16'h0;
    run_to(400);
    check("bounce_released", 16'(key_pressed), 16'h0);

    // Keys 0 and F together: pressed, but no event
    keys = 16'h8001;
    run_to(462);
    check("multi_before", 16'(key_pressed), 16'h0);
    run_to(463);
    check("multi_pressed", 16'(key_pressed), 16'h1);
    check("multi_no_event", 16'(key_valid), 16'h0);

    // Key 5 left unacked, then key 9: second event is dropped
    keys = 16'h0;
    run_to(526);
    check("drop_clear", 16'(key_pressed), 16'h0);
    keys = 16'h0020;
    run_to(589);
    check("drop_k5_valid", 16'(key_valid), 16'h1);
    check("drop_k5_code", 16'(key_code), 16'h5);
    keys = 16'h0;
    run_to(652);
    check("drop_k5_released", 16'(key_pressed), 16'h0);
    check("drop_valid_held", 16'(key_valid), 16'h1);
    keys = 16'h0200;
`ifdef KEYPAD_OVERRUN_EN
    run_to(714);
    check("ovr_before", 16'(overrun), 16'h0);
`endif
    run_to(715);
    check("drop_code_kept", 16'(key_code), 16'h5);
    check("drop_valid", 16'(key_valid), 16'h1);
    check("drop_k9_pressed", 16'(key_pressed), 16'h1);
`ifdef KEYPAD_OVERRUN_EN
    check("ovr_set", 16'(overrun), 16'h1);
`endif
    key_ack = 1'b1;
    run_to(716);
    key_ack = 1'b0;
    check("drop_ack_valid", 16'(key_valid), 16'h0);
    check("drop_ack_code", 16'(key_code), 16'h5);
`ifdef KEYPAD_OVERRUN_EN
    check("ovr_cleared", 16'(overrun), 16'h0);
`endif

    // Repeat, acking on the cycle the key 9 event is raised
    keys = 16'h0;
    run_to(778);
    check("rep_clear", 16'(key_pressed), 16'h0);
    keys = 16'h0020;
    run_to(841);
    check("rep_k5_valid", 16'(key_valid), 16'h1);
    check("rep_k5_code", 16'(key_code), 16'h5);
    keys = 16'h0;
    run_to(904);
    keys = 16'h0200;
    run_to(966);
    check("rep_pending_code", 16'(key_code), 16'h5);
    key_ack = 1'b1;
    run_to(967);
    key_ack = 1'b0;
    check("rep_k9_code", 16'(key_code), 16'h9);
    check("rep_k9_valid", 16'(key_valid), 16'h1);
`ifdef KEYPAD_OVERRUN_EN
    check("rep_ovr", 16'(overrun), 16'h0);
`endif
    run_to(968);
    check("rep_k9_hold", 16'(key_valid), 16'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/keypad_scan_ctrl.md
Name: keypad_scan_ctrl

Overview:
Scan sequencer and debouncer for the 4x4 matrix keypad.
- Drives one column low at a time and waits a settle time before sampling the four row lines.
- Builds a 16-bit key map per full scan and accepts it only after DEBOUNCE_SCANS identical consecutive scans.
- Reports each new single-key press to the downstream consumer through a valid/ack handshake.

Parameters:
SETTLE_CYCLES, 1000, cycles a column is held low before rows are sampled; legal range is 3 or more (covers the 2-FF row synchronizer).
DEBOUNCE_SCANS, 4, number of identical consecutive full scans required to accept a key map; legal range is 1 to 15.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
enable  in  1  scan enable
row  in  4  keypad rows; active-low, externally pulled up, asynchronous
column  out  4  keypad column drive; active-low, one-cold while scanning
key_code  out  4  index of the pressed key: column_index*4 + row_index
key_valid  out  1  new-key event pending; held until acked
key_ack  in  1  consumer accepts key_code
key_pressed  out  1  debounced map is non-zero

Behaviour:
- Reset: column=4'b1111, key_code=0, key_valid=0, key_pressed=0, overrun=0.
- Reset also clears internally: state=IDLE, col_idx=0, settle counter, snapshot, prev map, debounced map, stable_cnt.
- row passes through a 2-FF synchronizer. Internal pressed bit = ~row_sync.
- FSM states: IDLE, DRIVE, SAMPLE, EOS.
- IDLE: column=4'b1111. When enable=1, go to DRIVE with col_idx=0.
- DRIVE: column = ~(1<<col_idx). Count SETTLE_CYCLES cycles, then go to SAMPLE.
- SAMPLE (1 cycle): snapshot[col_idx*4 +: 4] <= ~row_sync.
  - If col_idx==3, go to EOS.
  - Otherwise col_idx++ and go to DRIVE.
- Column period = SETTLE_CYCLES+1 cycles. Full scan = 4*(SETTLE_CYCLES+1)+1 cycles, EOS included.
- EOS (1 cycle): debounce compare on the completed snapshot, then col_idx=0 and go to DRIVE.
  - If snapshot == prev: stable_cnt++, saturating at DEBOUNCE_SCANS.
  - Otherwise: prev <= snapshot and stable_cnt <= 1.
  - When stable_cnt reaches DEBOUNCE_SCANS (transition edge only), debounced <= snapshot.
- Press event: raised when debounced changes from 0 to exactly one set bit.
  - key_code <= index of that bit; key_valid <= 1 on the cycle after EOS.
  - Multi-key maps, releases, and transitions between non-zero maps raise no event.
  - A held key never repeats.
- key_pressed = (debounced != 0), registered.
- Handshake: key_ack sampled while key_valid=1 clears key_valid on the next cycle. key_ack while key_valid=0 is ignored.
- New event on the same cycle key_ack is sampled: the new code loads and key_valid stays 1. The old event counts as consumed.
- New event while key_valid=1 with no ack: the event is dropped and key_code is unchanged (see the optional feature).
- enable falls mid-scan: go to IDLE immediately, column=4'b1111, partial snapshot discarded. prev, debounced, stable_cnt, key_valid and key_code are retained. Re-enable restarts at col_idx=0.
- rst asserted mid-scan: all state returns to reset values asynchronously. column=4'b1111 from the reset edge.

Optional Feature:
KEYPAD_OVERRUN_EN
- Defined: adds an output port overrun (1 bit, reset 0). It is set when an event is dropped because key_valid=1 and no ack was given. It is sticky and cleared only by a key_ack that clears key_valid.
- Undefined: no port; dropped events are silent.

Test Plan:
- All scenarios use SETTLE_CYCLES=4 and DEBOUNCE_SCANS=3, giving a 21-cycle scan.
- Reset/idle: rst=1 then 0 with enable=0 -> column=1111 and all outputs 0 for 100 cycles. Assert rst mid-DRIVE -> column=1111 on the same edge.
- Sequencing: enable=1 -> column drives 1110, 1101, 1011, 0111 for 5 cycles each, plus an EOS cycle at 1111-hold-free, repeating with a 21-cycle period. enable=0 mid-scan -> column=1111 on the next cycle.
- Single press: model pulls row[2] low whenever column[1]=0, held -> after the 3rd identical scan, key_valid=1 and key_code=4'h6, key_pressed=1. key_ack pulse -> key_valid=0 next cycle. No second event while held. Release -> key_pressed=0 after 3 scans.
- Bounce: key 4'hA toggled on alternate scans for 4 scans, then held -> exactly one event, key_code=4'hA, raised 3 scans after the last toggle.
- Multi-key: keys 0 and F pressed together from an empty map -> no key_valid, key_pressed=1.
- Overrun (macro defined): press 5, no ack, release, press 9 -> key_code stays 5 and overrun=1. Ack -> key_valid=0 and overrun=0. Repeat with key_ack on the event cycle -> key_code=9, key_valid=1, overrun=0.
